debounce_sync: RTL

Input conditioner that sits directly upstream of the team's positive-edge storage flop stage. It takes a raw, asynchronous, possibly bouncing level (a switch or external pin), synchronises it into the `clk` domain, and debounces it with a saturating stability counter. It delivers a clean level `dout`, plus single-cycle `rise` and `fall` pulses, ready to drive the `d` input of the downstream flop.

---
 rtl/seq_pkg.sv | 15 +
 rtl/sync_chain.sv | 23 ++
 rtl/debounce_sync.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the input-conditioning path: debounce FSM state
// encoding and default synchroniser/debounce depths.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'b00,
        ST_CHK_HI = 2'b01,
        ST_HIGH   = 2'b11,
        ST_CHK_LO = 2'b10
    } state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous level; q is the last stage.
module sync_chain #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises a raw level and debounces it with a saturating stability counter,
// producing a clean registered level plus one-cycle rise/fall pulses.
module debounce_sync
    import seq_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s;

    sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s)
    );

    // Pulses default low every cycle; with en low everything else holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                case (state)
                    ST_LOW: begin
                        if (s) begin
                            state <= ST_CHK_HI;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    ST_CHK_HI: begin
                        if (!s) begin
                            state <= ST_LOW;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= ST_HIGH;
                            cnt   <= '0;
                            dout  <= 1'b1;
                            rise  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (!s) begin
                            state <= ST_CHK_LO;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    ST_CHK_LO: begin
                        if (s) begin
                            state <= ST_HIGH;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= ST_LOW;
                            cnt   <= '0;
                            dout  <= 1'b0;
                            fall  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_LOW;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state == ST_CHK_HI) || (state == ST_CHK_LO);

endmodule
